// File: rtl/nbj_resolve_unit_if.sv
// Push/resolve/correction bundle between the frontend, the backend and nbj_resolve_unit.
// The slave modport is the resolve unit's view; the master modport is the frontend/backend view.
interface nbj_resolve_unit_if;
    logic        i_pushValid;
    logic        o_pushReady;
    logic [2:0]  i_pushType_3;
    logic [31:0] i_pushPc_32;
    logic [31:0] i_pushPredPc_32;
    logic [2:0]  i_pushBtbIndex_3;
    logic        i_resolveValid;
    logic [31:0] i_resolveTarget_32;
    logic [31:0] o_correctPc_32;
    logic [2:0]  o_correctPcIndex_3;
    logic        o_errType;
    logic        o_flush;

    modport slave (
        input  i_pushValid, i_pushType_3, i_pushPc_32, i_pushPredPc_32, i_pushBtbIndex_3,
        input  i_resolveValid, i_resolveTarget_32,
        output o_pushReady, o_correctPc_32, o_correctPcIndex_3, o_errType, o_flush
    );

    modport master (
        output i_pushValid, i_pushType_3, i_pushPc_32, i_pushPredPc_32, i_pushBtbIndex_3,
        output i_resolveValid, i_resolveTarget_32,
        input  o_pushReady, o_correctPc_32, o_correctPcIndex_3, o_errType, o_flush
    );
endinterface

// File: rtl/nbj_resolve_unit.sv
// Holds frontend jump predictions in program order, checks each against the resolved target,
// and emits a one-cycle correction plus flush on mispredict.
//   state    | meaning
//   ST_RUN   | accepting pushes and resolves
//   ST_REDIR | one-cycle redirect: correction outputs live, buffer emptied, inputs ignored
module nbj_resolve_unit #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_fire,
    input  logic             rst,
    nbj_resolve_unit_if.slave bus,
    output logic [3:0]       o_count_4,
    output logic [CNT_W-1:0] o_mispredictCount_16,
    output logic             o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [2:0] TYPE_JALR = 3'd3;

    typedef enum logic {ST_RUN, ST_REDIR} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]       corr_pc_q, corr_pc_d;
    logic [2:0]        corr_idx_q, corr_idx_d;
    logic              err_q, err_d, flush_q, flush_d, unf_q, unf_d;
    logic [CNT_W-1:0]  mc_q, mc_d;
    logic              push_en;

    logic [2:0]        type_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       pred_mem [DEPTH];
    logic [2:0]        idx_mem  [DEPTH];

    logic [PW-1:0]     count;
    logic              full, empty, head_match;
    logic [AW-1:0]     rd_idx, wr_idx;
    logic              unused_head_pc;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = (count == PW'(DEPTH));
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign head_match = (pred_mem[rd_idx] == bus.i_resolveTarget_32);
    // The jump PC is kept with the entry for debug visibility only.
    assign unused_head_pc = ^pc_mem[rd_idx];

    assign bus.o_pushReady        = (state_q == ST_RUN) && !full;
    assign bus.o_correctPc_32     = corr_pc_q;
    assign bus.o_correctPcIndex_3 = corr_idx_q;
    assign bus.o_errType          = err_q;
    assign bus.o_flush            = flush_q;
    assign o_count_4              = 4'(count);
    assign o_mispredictCount_16   = mc_q;
    assign o_underflow            = unf_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        corr_pc_d  = '0;
        corr_idx_d = '0;
        err_d      = 1'b0;
        flush_d    = 1'b0;
        mc_d       = mc_q;
        unf_d      = unf_q;
        push_en    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.i_resolveValid && !empty) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    if (head_match) begin
                        // The pop frees a slot this edge, so a push is taken even when full.
                        push_en = bus.i_pushValid;
                    end else begin
                        flush_d = 1'b1;
                        state_d = ST_REDIR;
                        rd_ptr_d = wr_ptr_q;
                        if (~&mc_q) mc_d = mc_q + CNT_W'(1);
                        if (bus.i_resolveTarget_32 != 32'd0) begin
                            corr_pc_d  = bus.i_resolveTarget_32;
                            corr_idx_d = idx_mem[rd_idx];
                            err_d      = (type_mem[rd_idx] != TYPE_JALR);
                        end
                    end
                end else begin
                    if (bus.i_resolveValid) unf_d = 1'b1;
                    push_en = bus.i_pushValid && !full;
                end
                if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
            end
            ST_REDIR: begin
                rd_ptr_d = wr_ptr_q;
                state_d  = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            corr_pc_q  <= '0;
            corr_idx_q <= '0;
            err_q      <= 1'b0;
            flush_q    <= 1'b0;
            mc_q       <= '0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            corr_pc_q  <= corr_pc_d;
            corr_idx_q <= corr_idx_d;
            err_q      <= err_d;
            flush_q    <= flush_d;
            mc_q       <= mc_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge i_fire) begin
        if (push_en) begin
            type_mem[wr_idx] <= bus.i_pushType_3;
            pc_mem[wr_idx]   <= bus.i_pushPc_32;
            pred_mem[wr_idx] <= bus.i_pushPredPc_32;
            idx_mem[wr_idx]  <= bus.i_pushBtbIndex_3;
        end
    end
endmodule
